// File: rtl/johnson_dec_pkg.sv
// Shared types, phase constants and the pair decode for the Johnson sequence decoder.
package johnson_dec_pkg;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  typedef enum logic [1:0] {NONE, FWD, REV, ILLEGAL} step_e;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam int               ERR_W   = 3;
  localparam logic [ERR_W-1:0] ERR_SAT = 3'd7;

  // (A,B): 00 -> 0, 10 -> 1, 11 -> 2, 01 -> 3
  function automatic logic [1:0] pair_to_phase(input logic a, input logic b);
    case ({a, b})
      2'b00:   return PH0;
      2'b10:   return PH1;
      2'b11:   return PH2;
      default: return PH3;
    endcase
  endfunction

endpackage

// File: rtl/johnson_dec_sync.sv
// STAGES-deep single-bit synchronizer, async active-low reset to 0.
module johnson_dec_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/johnson_seq_decoder.sv
// Checks a synchronized two-line Johnson sequence, reporting phase, lock, direction and errors.
// Optional: define JOHNSON_DEC_REVERSE_EN to accept reverse steps; otherwise they are illegal.
module johnson_seq_decoder
  import johnson_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic clk, rst_n, a_s, b_s, clr_s, unused_in;
  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign unused_in = ^io_in[7:5];

  johnson_dec_sync #(.STAGES(SYNC_STAGES)) u_sync_a   (.clk(clk), .rst_n(rst_n), .d(io_in[2]), .q(a_s));
  johnson_dec_sync #(.STAGES(SYNC_STAGES)) u_sync_b   (.clk(clk), .rst_n(rst_n), .d(io_in[3]), .q(b_s));
  johnson_dec_sync #(.STAGES(SYNC_STAGES)) u_sync_clr (.clk(clk), .rst_n(rst_n), .d(io_in[4]), .q(clr_s));

  state_e           state_q, state_d;
  step_e            step;
  logic [1:0]       pair_q, pair_d, phase_q, phase_d, prev_ph, delta;
  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d, step_dir, legal, err_hit;
  logic             err_stk_q, err_stk_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d, err_base;

  // Step classification from the phase distance between this and last cycle's pair
  always_comb begin
    pair_d  = {a_s, b_s};
    phase_d = pair_to_phase(a_s, b_s);
    prev_ph = pair_to_phase(pair_q[1], pair_q[0]);
    delta   = phase_d - prev_ph;
    step    = NONE;
    if (pair_d != pair_q) begin
      case (delta)
        2'd1:    step = FWD;
`ifdef JOHNSON_DEC_REVERSE_EN
        2'd3:    step = REV;
`endif
        default: step = ILLEGAL;
      endcase
    end
    legal    = (step == FWD) || (step == REV);
    step_dir = (step == REV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (legal && cnt_d == 4'(LOCK_COUNT)) state_d = LOCKED;
      LOCKED:  if (step == ILLEGAL) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    err_hit = 1'b0;
    if (state_q == HUNT) begin
      if (legal) begin
        if (step_dir == dir_q) cnt_d = cnt_q + 4'd1;
        else begin
          cnt_d = 4'd1;
          dir_d = step_dir;
        end
      end else if (step == ILLEGAL) cnt_d = 4'd0;
    end else begin
      if (legal) dir_d = step_dir;
      else if (step == ILLEGAL) begin
        cnt_d   = 4'd0;
        err_hit = 1'b1;
      end
    end
    // Clear is applied before a same-cycle error is counted
    err_base  = clr_s ? '0 : err_cnt_q;
    err_cnt_d = err_base;
    err_stk_d = clr_s ? 1'b0 : err_stk_q;
    if (err_hit) begin
      err_stk_d = 1'b1;
      if (err_base != ERR_SAT) err_cnt_d = err_base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q    <= 2'b00;
      phase_q   <= PH0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      err_stk_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pair_q    <= pair_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      err_stk_q <= err_stk_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef JOHNSON_DEC_REVERSE_EN
  assign io_out = {dir_q, err_cnt_q, err_stk_q, state_q == LOCKED, phase_q};
`else
  assign io_out = {1'b0, err_cnt_q, err_stk_q, state_q == LOCKED, phase_q};
`endif

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// Directed bench for johnson_seq_decoder; expected outputs are queued at drive time and checked on arrival.
module tb_johnson_seq_decoder;

  logic       clk = 1'b0, rst_n = 1'b0, a = 1'b0, b = 1'b0, clr = 1'b0;
  logic [7:0] io_in, io_out;

  assign io_in = {3'b000, clr, b, a, rst_n, clk};

  johnson_seq_decoder #(.SYNC_STAGES(2), .LOCK_COUNT(4)) dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      tag;
  } sb_t;

  sb_t        sb[$];
  sb_t        cur_e;
  int         cyc = 0, checks = 0, errors = 0;
  logic [7:0] last_exp = 8'h00;
  logic [1:0] e_ph = 2'd0;
  logic       e_lk = 1'b0, e_stk = 1'b0, e_dir = 1'b0;
  logic [2:0] e_cnt = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur_e = sb.pop_front();
      chk(cur_e.tag, io_out, cur_e.exp);
    end
  end

  // Drive the pair for phase ph (optionally with a 1-cycle err_clr pulse); the
  // caller has already set e_* to the state expected after this step.
  task automatic go(input logic [1:0] ph, input string tag, input bit pulse_clr = 1'b0);
    sb_t        pre, post;
    logic [7:0] nx;
    e_ph = ph;
    nx   = {e_dir, e_cnt, e_stk, e_lk, e_ph};
    case (ph)
      2'd0:    begin a = 1'b0; b = 1'b0; end
      2'd1:    begin a = 1'b1; b = 1'b0; end
      2'd2:    begin a = 1'b1; b = 1'b1; end
      default: begin a = 1'b0; b = 1'b1; end
    endcase
    clr = pulse_clr;
    pre.due  = cyc + 2; pre.exp  = last_exp; pre.tag  = {tag, "_pre"};
    post.due = cyc + 3; post.exp = nx;       post.tag = tag;
    sb.push_back(pre);
    sb.push_back(post);
    last_exp = nx;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic relock(input string tag);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) e_lk = 1'b1;
      go(2'(e_ph + 2'd1), tag);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset", io_out, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_reset", io_out, 8'h00);

    // forward lock from reset
    go(2'd1, "f1"); go(2'd2, "f2"); go(2'd3, "f3");
    e_lk = 1'b1;
    go(2'd0, "f4_lock");
    go(2'd1, "locked_fwd");

    // 10 -> 01 while locked
    e_lk = 1'b0; e_stk = 1'b1; e_cnt = 3'd1;
    go(2'd3, "err1");
    relock("relock1");

    // saturation
    for (int i = 0; i < 9; i++) begin
      e_lk = 1'b0; e_stk = 1'b1;
      if (e_cnt != 3'd7) e_cnt = e_cnt + 3'd1;
      go(2'(e_ph + 2'd2), "sat_err");
      relock("sat_relock");
    end
    chk("sat_cnt", {5'b0, io_out[6:4]}, 8'd7);

    e_cnt = 3'd0; e_stk = 1'b0;
    go(e_ph, "clr", 1'b1);

`ifdef JOHNSON_DEC_REVERSE_EN
    e_dir = 1'b1;
    go(2'(e_ph - 2'd1), "rev_locked");
    e_dir = 1'b0;
    go(2'(e_ph + 2'd1), "fwd_locked");
    e_lk = 1'b0; e_stk = 1'b1; e_cnt = 3'd1;
    go(2'(e_ph + 2'd2), "rev_prep_err");
    e_dir = 1'b1;
    go(2'(e_ph - 2'd1), "r1");
    go(2'(e_ph - 2'd1), "r2");
    go(2'(e_ph - 2'd1), "r3");
    e_lk = 1'b1;
    go(2'(e_ph - 2'd1), "r4_lock");
    e_dir = 1'b0;
    go(2'(e_ph + 2'd1), "rev_to_fwd");
`else
    e_lk = 1'b0; e_stk = 1'b1; e_cnt = 3'd1;
    go(2'(e_ph - 2'd1), "rev_err");
    for (int i = 0; i < 4; i++) go(2'(e_ph - 2'd1), "rev_hunt");
    relock("rev_relock");
`endif

    // clear and error in the same cycle: count restarts at 1
    e_lk = 1'b0; e_stk = 1'b1; e_cnt = 3'd1;
    go(2'(e_ph + 2'd2), "clr_err", 1'b1);
    relock("relock2");
    go(2'(e_ph + 2'd1), "pre_rst");

    // async reset between edges
    #3;
    rst_n = 1'b0; a = 1'b0; b = 1'b0;
    #1;
    chk("rst_async", io_out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_exp = 8'h00;
    e_ph = 2'd0; e_lk = 1'b0; e_stk = 1'b0; e_cnt = 3'd0; e_dir = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_hold", io_out, 8'h00);
    relock("post_rst");

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drain", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
